// File: rtl/ieu_cdb_driver_pkg.sv
// rtl/ieu_cdb_driver_pkg.sv - shared opcode/result types for the integer execution unit CDB driver
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 6
`endif

package ieu_cdb_driver_pkg;

    localparam int IEU_DW = `DATA_WIDTH;
    localparam int IEU_AW = `ADDR_WIDTH;
    localparam int IEU_TW = `TAG_WIDTH;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13
    } opcode_t;

    typedef struct packed {
        logic [IEU_DW-1:0] data;
        logic [IEU_AW-1:0] addr;
        logic              redirect;
        logic [IEU_TW-1:0] tag;
    } ieu_result_t;

`ifdef IEU_BRANCH_EN
    // B-type immediate: {insn[31], insn[7], insn[30:25], insn[11:8], 0}, sign-extended.
    function automatic logic [IEU_AW-1:0] b_imm(input logic [31:0] insn);
        return {{(IEU_AW-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction
`endif

endpackage

// File: rtl/ieu_cdb_driver_result_queue.sv
// rtl/ieu_cdb_driver_result_queue.sv - result FIFO between the EX register and the CDB port
module ieu_result_queue
    import ieu_cdb_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       flush,
    input  logic                       push,
    input  ieu_result_t                push_data,
    input  logic                       pop,
    output ieu_result_t                head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    ieu_result_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Full push+pop writes the slot being read this edge; head is sampled before the write lands.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ieu_cdb_driver.sv
// rtl/ieu_cdb_driver.sv - integer ALU/branch unit driving one CDB port; IEU_BRANCH_EN enables branch resolution
module ieu_cdb_driver
    import ieu_cdb_driver_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int TAG_WIDTH  = `TAG_WIDTH,
    parameter int OQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_flush,
    input  logic                  i_fu_valid,
    input  opcode_t               i_fu_opcode,
    input  logic [ADDR_WIDTH-1:0] i_fu_iaddr,
    input  logic [DATA_WIDTH-1:0] i_fu_insn,
    input  logic [DATA_WIDTH-1:0] i_fu_src_a,
    input  logic [DATA_WIDTH-1:0] i_fu_src_b,
    input  logic [TAG_WIDTH-1:0]  i_fu_tag,
    output logic                  o_fu_stall,
    output logic                  o_cdb_req,
    input  logic                  i_cdb_gnt,
    output logic                  o_cdb_en,
    output logic                  o_cdb_redirect,
    output logic [DATA_WIDTH-1:0] o_cdb_data,
    output logic [ADDR_WIDTH-1:0] o_cdb_addr,
    output logic [TAG_WIDTH-1:0]  o_cdb_tag
);

    localparam int CW = $clog2(OQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(OQ_DEPTH);

    logic          accept;
    logic          pop;
    logic          ex_valid;
    ieu_result_t   ex_res;
    ieu_result_t   alu_res;
    ieu_result_t   q_head;
    logic [CW-1:0] q_count;
    logic [CW:0]   occupancy;
    logic [4:0]    shamt;

    // Credit: every instruction in EX already owns a queue slot.
    assign occupancy  = {1'b0, q_count} + {{CW{1'b0}}, ex_valid};
    assign o_fu_stall = occupancy >= DEPTH_L;
    assign o_cdb_req  = q_count != '0;
    assign accept     = i_fu_valid && !o_fu_stall;
    assign pop        = o_cdb_req && i_cdb_gnt;
    assign shamt      = i_fu_src_b[4:0];

`ifdef IEU_BRANCH_EN
    logic [ADDR_WIDTH-1:0] br_link;
    logic [ADDR_WIDTH-1:0] br_target;
    logic                  br_eq;
    logic                  br_lt;
    logic                  unused_insn;

    assign br_link     = i_fu_iaddr + ADDR_WIDTH'(4);
    assign br_target   = i_fu_iaddr + b_imm(i_fu_insn[31:0]);
    assign br_eq       = i_fu_src_a == i_fu_src_b;
    assign br_lt       = $signed(i_fu_src_a) < $signed(i_fu_src_b);
    assign unused_insn = ^{i_fu_insn[24:12], i_fu_insn[6:0]};
`else
    logic unused_insn;
    assign unused_insn = ^i_fu_insn;
`endif

    always_comb begin
        alu_res          = '0;
        alu_res.addr     = i_fu_iaddr;
        alu_res.tag      = i_fu_tag;
        alu_res.redirect = 1'b0;
        case (i_fu_opcode)
            OP_ADD:  alu_res.data = i_fu_src_a + i_fu_src_b;
            OP_SUB:  alu_res.data = i_fu_src_a - i_fu_src_b;
            OP_AND:  alu_res.data = i_fu_src_a & i_fu_src_b;
            OP_OR:   alu_res.data = i_fu_src_a | i_fu_src_b;
            OP_XOR:  alu_res.data = i_fu_src_a ^ i_fu_src_b;
            OP_SLL:  alu_res.data = i_fu_src_a << shamt;
            OP_SRL:  alu_res.data = i_fu_src_a >> shamt;
            OP_SRA:  alu_res.data = $signed(i_fu_src_a) >>> shamt;
            OP_SLT:  alu_res.data = {{(DATA_WIDTH-1){1'b0}},
                                     $signed(i_fu_src_a) < $signed(i_fu_src_b)};
            OP_SLTU: alu_res.data = {{(DATA_WIDTH-1){1'b0}}, i_fu_src_a < i_fu_src_b};
`ifdef IEU_BRANCH_EN
            OP_BEQ: begin
                alu_res.data     = DATA_WIDTH'(br_link);
                alu_res.addr     = br_target;
                alu_res.redirect = br_eq;
            end
            OP_BNE: begin
                alu_res.data     = DATA_WIDTH'(br_link);
                alu_res.addr     = br_target;
                alu_res.redirect = !br_eq;
            end
            OP_BLT: begin
                alu_res.data     = DATA_WIDTH'(br_link);
                alu_res.addr     = br_target;
                alu_res.redirect = br_lt;
            end
            OP_BGE: begin
                alu_res.data     = DATA_WIDTH'(br_link);
                alu_res.addr     = br_target;
                alu_res.redirect = !br_lt;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ex_valid <= 1'b0;
            ex_res   <= '0;
        end else begin
            ex_valid <= accept && !i_flush;
            if (accept) begin
                ex_res <= alu_res;
            end
        end
    end

    ieu_result_queue #(
        .DEPTH (OQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (i_flush),
        .push      (ex_valid),
        .push_data (ex_res),
        .pop       (pop),
        .head      (q_head),
        .count     (q_count)
    );

    // A grant during flush still pops (the queue clears anyway) but never broadcasts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_cdb_en   <= 1'b0;
            o_cdb_data <= '0;
            o_cdb_addr <= '0;
            o_cdb_tag  <= '0;
        end else if (i_flush) begin
            o_cdb_en <= 1'b0;
        end else if (pop) begin
            o_cdb_en   <= 1'b1;
            o_cdb_data <= q_head.data;
            o_cdb_addr <= q_head.addr;
            o_cdb_tag  <= q_head.tag;
        end else begin
            o_cdb_en <= 1'b0;
        end
    end

`ifdef IEU_BRANCH_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_cdb_redirect <= 1'b0;
        end else begin
            o_cdb_redirect <= pop && !i_flush && q_head.redirect;
        end
    end
`else
    logic unused_head_redirect;
    assign unused_head_redirect = q_head.redirect;
    assign o_cdb_redirect       = 1'b0;
`endif

endmodule

// File: doc/ieu_cdb_driver.md
# ieu_cdb_driver

Integer execution unit sitting downstream of a reservation station. It accepts one issued instruction per cycle over the functional-unit interface, computes the ALU/branch result in a single registered stage and buffers results in a small output queue. It then drives one common data bus (CDB) port under a request/grant handshake with the CDB arbiter. It is the consumer of the issue interface and the producer of CDB broadcasts.

## Interface
- DATA_WIDTH, `DATA_WIDTH, operand/result width
- ADDR_WIDTH, `ADDR_WIDTH, instruction address width
- TAG_WIDTH, `TAG_WIDTH, ROB tag width
- OQ_DEPTH, 4, output queue entries; power of two, at least 2
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush
- i_fu_valid  in  1  issued instruction present
- i_fu_opcode  in  opcode_t  operation
- i_fu_iaddr  in  ADDR_WIDTH  instruction address
- i_fu_insn  in  DATA_WIDTH  raw instruction (branch immediate source)
- i_fu_src_a / i_fu_src_b  in  DATA_WIDTH  operands
- i_fu_tag  in  TAG_WIDTH  destination tag
- o_fu_stall  out  1  unit cannot accept an instruction this cycle
- o_cdb_req  out  1  request for the CDB port
- i_cdb_gnt  in  1  grant, valid only while o_cdb_req is high
- o_cdb_en / o_cdb_redirect  out  1  broadcast valid / taken branch
- o_cdb_data  out  DATA_WIDTH  result
- o_cdb_addr  out  ADDR_WIDTH  redirect target, or iaddr
- o_cdb_tag  out  TAG_WIDTH  destination tag

## Operation
- Accept: i_fu_valid && ~o_fu_stall. The EX register captures the opcode, result, redirect, addr and tag. Input while stalled is ignored; the reservation station holds it.
- Opcodes: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA (shift by src_b[4:0]), OP_SLT and OP_SLTU (result 0 or 1). Unlisted opcodes produce data 0 and redirect 0.
- Branches OP_BEQ, OP_BNE, OP_BLT, OP_BGE:
  - data = iaddr+4.
  - addr = iaddr + sign-extended B-immediate from insn[31:7].
  - redirect = condition true.
- Non-branches: addr = iaddr, redirect 0.
- Arithmetic wraps modulo 2^DATA_WIDTH; iaddr+4 and the target wrap modulo 2^ADDR_WIDTH.
- EX valid moves into the queue tail on the next edge, unconditionally. A slot is guaranteed by the credit rule.
- Credit rule: o_fu_stall = (count + ex_valid) >= OQ_DEPTH, purely from registers.
- o_cdb_req = count != 0.
- On req && gnt: the head is popped and registered onto the o_cdb_* outputs. o_cdb_en is high for exactly one cycle per grant.
- A simultaneous push and pop is permitted at any count, including full.
- Pointers wrap modulo OQ_DEPTH; count ranges over 0..OQ_DEPTH.

## Timing
- Reset values: o_cdb_en, o_cdb_redirect, o_cdb_req, o_fu_stall = 0; o_cdb_data, addr and tag = 0. Count, pointers and ex_valid = 0.
- Latency with the queue empty and grant immediate:
  - accept at cycle N;
  - EX holds the result at N+1;
  - o_cdb_req at N+2;
  - o_cdb_en at N+3.
- Sustained throughput is one result per cycle while gnt is held high.
- Flush:
  - next edge clears ex_valid, count and pointers, and forces o_cdb_en = 0;
  - flush overrides a same-cycle accept and grant;
  - the grant in that cycle is consumed with no broadcast.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); no partial broadcast.

## Configuration
- IEU_BRANCH_EN defined: branch opcodes behave as above.
- IEU_BRANCH_EN undefined:
  - branch opcodes are treated as unlisted (data 0);
  - o_cdb_redirect is tied 0;
  - o_cdb_addr always carries iaddr;
  - no immediate decode logic is instantiated.

## Structure
- opcode_t stays in the shared types package.
- Add to types a struct ieu_result_t {data, addr, redirect, tag} used for EX, queue entries and CDB output.
- One sub-module, ieu_result_queue: a parameterised FIFO of ieu_result_t with push, pop, flush, count and head outputs, and the same asynchronous reset.
- The ALU and branch compare are combinational logic inside ieu_cdb_driver.

## Test plan
- OP_ADD with a=0xFFFFFFFF, b=2, tag=5, gnt held 1:
  - accept at N; o_cdb_req at N+2;
  - at N+3 o_cdb_en=1, data=0x1, tag=5, redirect=0, addr=iaddr.
- OP_BEQ at iaddr=0x100, insn immediate -8, a=b=7:
  - data=0x104, addr=0xF8, redirect=1;
  - with IEU_BRANCH_EN undefined: redirect=0, addr=0x100.
- gnt held 0 while issuing OP_OR every cycle with OQ_DEPTH=4:
  - o_fu_stall rises after 4 accepts;
  - releasing gnt gives 4 consecutive o_cdb_en pulses in order, then stall drops.
- Queue full, with accept and grant in the same cycle: count stays at OQ_DEPTH, no entry is lost, and order is preserved.
- Flush with 3 queued entries, one in EX and gnt high: no o_cdb_en the following cycle, o_cdb_req=0, o_fu_stall=0.
- n_rst asserted mid-stream: all outputs are 0 asynchronously; the first accept after release yields o_cdb_en exactly 3 cycles later.
